// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the RV64M div/rem group.
// Optional macro DIV_SEQ_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            kill,
    output logic            in_ready,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [1:0]      dbg_state
);

    localparam int HALF = XLEN / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   div_q;
    logic              quo_neg_q;
    logic              rem_neg_q;
    logic              is_rem_q;
    logic              is_word_q;
    logic [XLEN-1:0]   result_q;
    logic              result_valid_q;

    logic              op_ok;
    logic              acc_signed;
    logic              acc_word;
    logic              acc_rem;
    logic [XLEN-1:0]   a_ext;
    logic [XLEN-1:0]   b_ext;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   min_neg;
    logic              div_zero;
    logic              ovf;
    logic              early_out;
    logic              special;
    logic              start;
    logic [XLEN-1:0]   sp_quo;
    logic [XLEN-1:0]   sp_rem;
    logic [XLEN-1:0]   sp_res_d;
    logic [XLEN:0]     part;
    logic [XLEN:0]     diff;
    logic              no_borrow;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;
    logic [XLEN-1:0]   fin_quo;
    logic [XLEN-1:0]   fin_rem;
    logic [XLEN-1:0]   calc_res_d;

    // Word results are always sign-extended from bit HALF-1, even for divuw/remuw.
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic word);
        fmt = word ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    always_comb begin
        op_ok      = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
        acc_signed = op[0] | op[2] | op[4] | op[6];
        acc_word   = op[2] | op[3] | op[6] | op[7];
        acc_rem    = |op[7:4];

        if (acc_word) begin
            a_ext = acc_signed ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]} : {{HALF{1'b0}}, src1[HALF-1:0]};
            b_ext = acc_signed ? {{HALF{src2[HALF-1]}}, src2[HALF-1:0]} : {{HALF{1'b0}}, src2[HALF-1:0]};
            min_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end else begin
            a_ext   = src1;
            b_ext   = src2;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end

        a_neg = acc_signed & a_ext[XLEN-1];
        b_neg = acc_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        div_zero = (b_ext == '0);
        ovf      = acc_signed && (a_ext == min_neg) && (b_ext == '1);
`ifdef DIV_SEQ_EARLY_OUT_EN
        early_out = !div_zero && (a_mag < b_mag);
`else
        early_out = 1'b0;
`endif
        special = div_zero | ovf | early_out;
        start   = (state_q == S_IDLE) & in_valid & op_ok & ~kill;

        // Special-case results are already in final signed form; no negation step.
        if (div_zero) begin
            sp_quo = '1;
            sp_rem = a_ext;
        end else if (ovf) begin
            sp_quo = a_ext;
            sp_rem = '0;
        end else begin
            sp_quo = '0;
            sp_rem = a_ext;
        end
        sp_res_d = fmt(acc_rem ? sp_rem : sp_quo, acc_word);

        part      = {rem_q, quo_q[XLEN-1]};
        diff      = part - {1'b0, div_q};
        no_borrow = ~diff[XLEN];
        rem_d     = no_borrow ? diff[XLEN-1:0] : part[XLEN-1:0];
        quo_d     = {quo_q[XLEN-2:0], no_borrow};

        fin_quo    = quo_neg_q ? -quo_d : quo_d;
        fin_rem    = rem_neg_q ? -rem_d : rem_d;
        calc_res_d = fmt(is_rem_q ? fin_rem : fin_quo, is_word_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            div_q          <= '0;
            quo_neg_q      <= 1'b0;
            rem_neg_q      <= 1'b0;
            is_rem_q       <= 1'b0;
            is_word_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (special) begin
                            state_q        <= S_DONE;
                            result_q       <= sp_res_d;
                            result_valid_q <= 1'b1;
                        end else begin
                            state_q   <= S_CALC;
                            cnt_q     <= acc_word ? CNT_W'(HALF) : CNT_W'(XLEN);
                            rem_q     <= '0;
                            // Word dividends sit in the top half so their MSB shifts out first.
                            quo_q     <= acc_word ? (a_mag << HALF) : a_mag;
                            div_q     <= b_mag;
                            quo_neg_q <= a_neg ^ b_neg;
                            rem_neg_q <= a_neg;
                            is_rem_q  <= acc_rem;
                            is_word_q <= acc_word;
                        end
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q        <= S_DONE;
                            result_q       <= calc_res_d;
                            result_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A kill arriving in DONE suppresses the commit pulse in that same cycle.
    assign result_valid = result_valid_q & ~kill;
    assign result       = result_q;
    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign stall        = start | (state_q == S_CALC);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed RV64M cases, abort paths and a
// randomized scoreboard run against a behavioural division model.
module tb_div_seq;

    localparam logic [7:0] OP_DIV   = 8'b0000_0001;
    localparam logic [7:0] OP_DIVU  = 8'b0000_0010;
    localparam logic [7:0] OP_DIVW  = 8'b0000_0100;
    localparam logic [7:0] OP_DIVUW = 8'b0000_1000;
    localparam logic [7:0] OP_REM   = 8'b0001_0000;
    localparam logic [7:0] OP_REMU  = 8'b0010_0000;
    localparam logic [7:0] OP_REMW  = 8'b0100_0000;
    localparam logic [7:0] OP_REMUW = 8'b1000_0000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        kill;
    logic        in_ready;
    logic        stall;
    logic        busy;
    logic [63:0] result;
    logic        result_valid;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    div_seq #(.XLEN(64), .CNT_W(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .op           (op),
        .src1         (src1),
        .src2         (src2),
        .kill         (kill),
        .in_ready     (in_ready),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RISC-V division semantics including the special cases.
    function automatic logic [63:0] ref_res(input logic [7:0] o, input logic [63:0] a, input logic [63:0] b);
        logic sgn, wrd, rm;
        logic [63:0] x, y, q, r, v;
        sgn = o[0] | o[2] | o[4] | o[6];
        wrd = o[2] | o[3] | o[6] | o[7];
        rm  = |o[7:4];
        if (wrd) begin
            x = sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            y = sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end else begin
            x = a;
            y = b;
        end
        if (y == 64'd0) begin
            q = '1;
            r = x;
        end else if (sgn && y == '1 && x == (wrd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
            q = x;
            r = 64'd0;
        end else if (sgn) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        v = rm ? r : q;
        ref_res = wrd ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    function automatic int exp_lat(input logic [7:0] o, input logic [63:0] a, input logic [63:0] b);
        logic sgn, wrd;
        logic [63:0] x, y, mx, my;
        sgn = o[0] | o[2] | o[4] | o[6];
        wrd = o[2] | o[3] | o[6] | o[7];
        x = wrd ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
        y = wrd ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
        mx = (sgn && x[63]) ? -x : x;
        my = (sgn && y[63]) ? -y : y;
        if (y == 64'd0) return 1;
        if (sgn && y == '1 && x == (wrd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
`ifdef DIV_SEQ_EARLY_OUT_EN
        if (mx < my) return 1;
`else
        if (mx < my && mx == 64'd1 && my == 64'd0) return 0;
`endif
        return wrd ? 33 : 65;
    endfunction

    // Drives one op from cycle 0 (called at posedge+1) until result_valid or budget expiry.
    task automatic issue(input logic [7:0] o, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output logic [63:0] res,
                         output int stall_cnt, output logic stall_done);
        lat = -1;
        res = '0;
        stall_cnt = 0;
        stall_done = 1'b1;
        in_valid = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = c;
                res = result;
                stall_done = stall;
                break;
            end
            if (stall) stall_cnt++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = '0;
    endtask

    task automatic run_directed(input string name, input logic [7:0] o, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] exp_v, input int exp_l);
        int lat, sc;
        logic [63:0] res, exp_r;
        logic sd;
        exp_q.push_back(exp_v);
        issue(o, a, b, lat, res, sc, sd);
        exp_r = exp_q.pop_front();
        checks++;
        if (res !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, res, exp_r);
        end
        checks++;
        if (lat !== exp_l) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_l);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        src1 = '0;
        src2 = '0;
        kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, stall, result_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset flags: got rdy/busy/stall/vld %b expected 1000", {in_ready, busy, stall, result_valid});
        end
        checks++;
        if (result !== 64'd0) begin
            errors++;
            $display("FAIL reset result: got %h expected 0", result);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset state: got %0d expected 0", dbg_state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_divu_timing;
        int lat, sc;
        logic [63:0] res, exp_r;
        logic sd;
        exp_q.push_back(64'd14);
        issue(OP_DIVU, 64'd100, 64'd7, lat, res, sc, sd);
        exp_r = exp_q.pop_front();
        checks++;
        if (res !== exp_r) begin
            errors++;
            $display("FAIL divu_100_7 result: got %h expected %h", res, exp_r);
        end
        checks++;
        if (lat !== 65) begin
            errors++;
            $display("FAIL divu_100_7 latency: got %0d expected 65", lat);
        end
        checks++;
        if (sc !== 65 || sd !== 1'b0) begin
            errors++;
            $display("FAIL divu_100_7 stall: got %0d high cycles, done-stall %b expected 65, 0", sc, sd);
        end
    endtask

    task automatic test_signed;
        run_directed("rem_m7_2", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_directed("div_m7_2", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    endtask

    task automatic test_special;
        run_directed("divw_ovf", OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_directed("remw_ovf", OP_REMW, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
        run_directed("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_directed("divu_by0", OP_DIVU, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_directed("remu_by0", OP_REMU, 64'h1234, 64'd0, 64'h1234, 1);
    endtask

    task automatic test_word;
        run_directed("divuw_ext", OP_DIVUW, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_directed("remuw_5_3", OP_REMUW, 64'd5, 64'd3, 64'd2, 33);
    endtask

    task automatic test_invalid_op;
        int bad_stall = 0;
        in_valid = 1'b1;
        op = 8'b0000_0011;
        src1 = 64'd9;
        src2 = 64'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (stall || busy || !in_ready) bad_stall++;
            @(posedge clk);
            #1;
            if (c == 1) op = 8'd0;
            if (c == 2) begin
                op = OP_DIV;
                kill = 1'b1;
            end
        end
        kill = 1'b0;
        in_valid = 1'b0;
        op = '0;
        checks++;
        if (bad_stall !== 0) begin
            errors++;
            $display("FAIL invalid_op_idle: got %0d busy/stall cycles expected 0", bad_stall);
        end
    endtask

    task automatic test_kill;
        int pulses = 0;
        in_valid = 1'b1;
        op = OP_DIV;
        src1 = 64'd1000;
        src2 = 64'd3;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(negedge clk);
        if (result_valid) pulses++;
        @(posedge clk);
        #1;
        kill = 1'b0;
        in_valid = 1'b0;
        op = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_to_idle: got busy %b ready %b expected 0 1", busy, in_ready);
        end
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL kill_no_pulse: got %0d pulses expected 0", pulses);
        end
        run_directed("after_kill", OP_DIVU, 64'd1000, 64'd3, 64'd333, 65);
    endtask

    task automatic test_reset_mid_calc;
        in_valid = 1'b1;
        op = OP_DIVU;
        src1 = 64'd12345;
        src2 = 64'd10;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, stall, result_valid} !== 4'b1000 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_calc flags: got rdy/busy/stall/vld %b state %0d expected 1000 0",
                     {in_ready, busy, stall, result_valid}, dbg_state);
        end
        checks++;
        if (result !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_calc result: got %h expected 0", result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int lat, sc;
        logic [63:0] a, b, res, exp_r;
        logic [7:0] o;
        logic sd;
        int el;
        for (int i = 0; i < 24; i++) begin
            o = 8'd1 << $urandom_range(0, 7);
            a = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0: b = 64'd0;
                1: b = {32'd0, 16'd0, 16'($urandom())};
                2: b = {$urandom(), $urandom()};
                3: b = '1;
                default: b = 64'($urandom_range(1, 1000));
            endcase
            if (i % 5 == 4) a = 64'($urandom_range(0, 20));
            el = exp_lat(o, a, b);
            exp_q.push_back(ref_res(o, a, b));
            issue(o, a, b, lat, res, sc, sd);
            exp_r = exp_q.pop_front();
            checks++;
            if (res !== exp_r) begin
                errors++;
                $display("FAIL rand%0d op %b a %h b %h: got %h expected %h", i, o, a, b, res, exp_r);
            end
            checks++;
            if (lat !== el) begin
                errors++;
                $display("FAIL rand%0d latency: got %0d expected %0d", i, lat, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu_timing();
        test_signed();
        test_special();
        test_word();
        test_invalid_op();
        test_kill();
        test_reset_mid_calc();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
